// File: rtl/clk_rst_seq_pkg.sv
// ============================================================================
// Module      : clk_rst_seq_pkg
// Description : Shared state encoding and parameter defaults for the
//               clock/reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_rst_seq_pkg;

    localparam int unsigned c_def_pll_rst_cycles = 16;
    localparam int unsigned c_def_lock_timeout   = 65536;
    localparam int unsigned c_def_hold_cycles    = 1024;

    typedef enum logic [1:0] {
        ST_PLLRST = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for asynchronous level signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/clk_rst_sequencer.sv
// ============================================================================
// Module      : clk_rst_sequencer
// Description : Sequences PLL reset, lock wait, lock hold and core reset
//               release; counts lock losses seen while running.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_rst_sequencer
    import clk_rst_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = c_def_pll_rst_cycles,
    parameter int unsigned LOCK_TIMEOUT   = c_def_lock_timeout,
    parameter int unsigned HOLD_CYCLES    = c_def_hold_cycles
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned c_cnt_max = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, HOLD_CYCLES);
    localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_pll_last  = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);

    logic               w_locked_s;
    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_loss;
    logic               r_pll_rst;
    logic               r_sys_reset;
    logic               r_ready;
    logic [7:0]         r_loss_cnt;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (locked),
        .o_q (w_locked_s)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt + c_cnt_w'(1);
        w_loss     = 1'b0;
        case (r_state)
            ST_PLLRST: begin
                if (r_cnt == c_pll_last) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_locked_s)                w_next = ST_HOLD;
                else if (r_cnt == c_wait_last) w_next = ST_PLLRST;
            end
            ST_HOLD: begin
                if (!w_locked_s)               w_next = ST_WAIT;
                else if (r_cnt == c_hold_last) w_next = ST_RUN;
            end
            ST_RUN: begin
                // Counter parked while running; lock loss outranks soft reset.
                w_cnt_next = '0;
                if (!w_locked_s) begin
                    w_next = ST_PLLRST;
                    w_loss = 1'b1;
                end else if (soft_reset) begin
                    w_next = ST_HOLD;
                end
            end
            default: w_next = ST_PLLRST;
        endcase
        if (w_next != r_state) w_cnt_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_PLLRST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_loss_cnt  <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_pll_rst   <= (w_next == ST_PLLRST);
            r_sys_reset <= (w_next != ST_RUN);
            r_ready     <= (w_next == ST_RUN);
            if (w_loss && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_reset     = r_sys_reset;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_loss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_clk_rst_sequencer.sv
// ============================================================================
// Module      : tb_clk_rst_sequencer
// Description : Self-checking bench for clk_rst_sequencer against a
//               countdown-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_rst_sequencer;

    localparam int P = 4;
    localparam int T = 100;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b1;
    logic       soft_reset = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clk_rst_sequencer #(
        .PLL_RST_CYCLES (P),
        .LOCK_TIMEOUT   (T),
        .HOLD_CYCLES    (H)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .locked        (locked),
        .soft_reset    (soft_reset),
        .pll_rst       (pll_rst),
        .sys_reset     (sys_reset),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: phase plus cycles remaining in that phase.
    typedef enum int {M_PLL, M_WAIT, M_HOLD, M_RUN} mphase_t;
    mphase_t m_phase  = M_PLL;
    int      m_rem    = P;
    int      m_losses = 0;
    bit      m_lq[$]  = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin : p_model
        bit ls;
        if (rst) begin
            m_phase  = M_PLL;
            m_rem    = P;
            m_losses = 0;
            m_lq     = '{1'b0, 1'b0};
        end else begin
            ls = m_lq.pop_front();
            m_lq.push_back(locked);
            case (m_phase)
                M_PLL: begin
                    m_rem--;
                    if (m_rem == 0) begin m_phase = M_WAIT; m_rem = T; end
                end
                M_WAIT: begin
                    if (ls) begin m_phase = M_HOLD; m_rem = H; end
                    else begin
                        m_rem--;
                        if (m_rem == 0) begin m_phase = M_PLL; m_rem = P; end
                    end
                end
                M_HOLD: begin
                    if (!ls) begin m_phase = M_WAIT; m_rem = T; end
                    else begin
                        m_rem--;
                        if (m_rem == 0) m_phase = M_RUN;
                    end
                end
                default: begin
                    if (!ls) begin
                        m_phase = M_PLL;
                        m_rem   = P;
                        if (m_losses < 255) m_losses++;
                    end else if (soft_reset) begin
                        m_phase = M_HOLD;
                        m_rem   = H;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check_eq("outputs_vs_model", {pll_rst, sys_reset, ready, lock_loss_cnt},
                 {m_phase == M_PLL, m_phase != M_RUN, m_phase == M_RUN, 8'(m_losses)});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_ready(input int max_cycles);
        int k = 0;
        while (!ready && k < max_cycles) begin
            step(1);
            k++;
        end
        check_eq("wait_ready_timeout", ready, 1);
    endtask

    initial begin : p_stim
        int rise_at, fall_at, sh, pl, k, d, sys_low, prev;
        int falls[$];
        int rises[$];

        step(3);
        check_eq("reset_state", {pll_rst, sys_reset, ready, lock_loss_cnt}, 11'h600);

        // Power-up with lock held high.
        rst = 1'b0;
        rise_at = -1;
        fall_at = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (ready && rise_at < 0)    rise_at = i;
            if (!pll_rst && fall_at < 0) fall_at = i;
        end
        check_eq("pll_rst_width", fall_at, P);
        check_eq("ready_latency_window", (rise_at >= P + 2 + H - 1) && (rise_at <= P + 2 + H + 1), 1);
        check_eq("loss_cnt_clean", lock_loss_cnt, 0);

        // Soft reset pulse while running.
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        sh = 0;
        pl = 0;
        for (int i = 0; i < 20; i++) begin
            sh += int'(sys_reset);
            pl |= int'(pll_rst);
            step(1);
        end
        check_eq("soft_hold_len", sh, H);
        check_eq("soft_no_pll_rst", pl, 0);
        check_eq("soft_back_ready", ready, 1);

        // Soft reset coinciding with the synchronised lock drop.
        locked = 1'b0;
        step(2);
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        locked = 1'b1;
        check_eq("simul_pll_rst", pll_rst, 1);
        check_eq("simul_ready", ready, 0);
        check_eq("simul_loss_cnt", lock_loss_cnt, 1);

        // Lock glitch after six hold cycles.
        k = 0;
        while (!(m_phase == M_HOLD && m_rem == H - 6) && k < 200) begin
            step(1);
            k++;
        end
        check_eq("reach_hold6", k < 200, 1);
        locked = 1'b0;
        step(3);
        locked = 1'b1;
        k = 3;
        while (!ready && k < 40) begin
            step(1);
            k++;
        end
        check_eq("glitch_ready_edge", k, 16);

        // Repeated lock losses, random low duration and coincident soft reset.
        for (int i = 0; i < 300; i++) begin
            wait_ready(60);
            locked = 1'b0;
            d = $urandom_range(1, 3);
            for (int j = 1; j <= 3; j++) begin
                if (j == 3) soft_reset = 1'($urandom_range(0, 1));
                step(1);
                soft_reset = 1'b0;
                if (j == d) locked = 1'b1;
            end
            check_eq("loss_response", {pll_rst, sys_reset, ready}, 3'b110);
            check_eq("loss_count", lock_loss_cnt, (i + 2 > 255) ? 255 : i + 2);
        end
        check_eq("loss_saturated", lock_loss_cnt, 255);

        // Asynchronous abort while running.
        wait_ready(60);
        rst = 1'b1;
        #1;
        check_eq("async_abort", {pll_rst, sys_reset, ready, lock_loss_cnt}, 11'h600);

        // No lock: periodic PLL reset pulses.
        locked = 1'b0;
        step(2);
        rst = 1'b0;
        prev = 1;
        sys_low = 0;
        for (int i = 1; i <= 230; i++) begin
            step(1);
            if (prev == 1 && !pll_rst) falls.push_back(i);
            if (prev == 0 && pll_rst)  rises.push_back(i);
            prev = int'(pll_rst);
            if (!sys_reset) sys_low++;
        end
        check_eq("nolock_fall_count", falls.size(), 3);
        check_eq("nolock_rise_count", rises.size(), 2);
        if (falls.size() >= 2 && rises.size() >= 1) begin
            check_eq("nolock_period", falls[1] - falls[0], P + T);
            check_eq("nolock_pulse_width", falls[1] - rises[0], P);
        end
        check_eq("nolock_sys_reset_held", sys_low, 0);

        // Random lock bursts, soft resets and occasional hard resets.
        locked = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) locked = ~locked;
            soft_reset = ($urandom_range(0, 14) == 0);
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0;
        soft_reset = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clk_rst_sequencer.md
CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, number of clk cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536, number of clk cycles to wait for lock before re-issuing a PLL reset.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1024, number of consecutive locked cycles required before releasing sys_reset.
REQ-004 clk  input  1  free-running 50 MHz reference clock, the same source as the PLL refclk; the only clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 locked  input  1  PLL lock indicator, asynchronous to clk.
REQ-007 soft_reset  input  1  synchronous request to re-run the hold phase, level-sensitive.
REQ-008 pll_rst  output  1  reset to the PLL rst input, active-high.
REQ-009 sys_reset  output  1  core reset, active-high, deasserted synchronously to clk.
REQ-010 ready  output  1  high only in RUN state.
REQ-011 lock_loss_cnt  output  8  count of lock losses seen in RUN state.

Function
REQ-012 SHALL synchronise locked through two flip-flops to form locked_s, with 2 cycles of latency; all decisions SHALL use locked_s only.
REQ-013 SHALL implement the states PLLRST, WAIT, HOLD and RUN, with one shared cycle counter cleared on every state transition.
REQ-014 PLLRST: pll_rst=1 and sys_reset=1; after PLL_RST_CYCLES cycles SHALL move to WAIT.
REQ-015 WAIT: pll_rst=0 and sys_reset=1; if locked_s=1, SHALL move to HOLD; if the counter reaches LOCK_TIMEOUT with locked_s=0, SHALL move to PLLRST.
REQ-016 HOLD: sys_reset=1; if locked_s=0 in any cycle, SHALL move to WAIT; after HOLD_CYCLES consecutive locked_s=1 cycles, SHALL move to RUN.
REQ-017 RUN: sys_reset=0 and ready=1; if locked_s=0, SHALL move to PLLRST and increment lock_loss_cnt; else if soft_reset=1, SHALL move to HOLD.
REQ-018 If lock loss and soft_reset occur in the same cycle, lock loss SHALL take priority.
REQ-019 lock_loss_cnt SHALL saturate at 255 and SHALL be cleared only by rst.
REQ-020 All outputs SHALL be registered; each output change SHALL appear one cycle after the state transition that causes it.
REQ-021 soft_reset SHALL be ignored in PLLRST, WAIT and HOLD.
REQ-022 Counter width SHALL be sized from the largest of PLL_RST_CYCLES, LOCK_TIMEOUT and HOLD_CYCLES; the counter SHALL never wrap.

Reset
REQ-023 On rst assertion, asynchronously: state=PLLRST, pll_rst=1, sys_reset=1, ready=0, lock_loss_cnt=0, counter=0, synchroniser flops=0.
REQ-024 After rst deasserts, SHALL start a full PLLRST phase of PLL_RST_CYCLES cycles.
REQ-025 rst asserted mid-operation, in any state, SHALL abort immediately to the reset values.

Structure
REQ-026 State encoding and parameter defaults SHALL live in the shared package clk_rst_seq_pkg.
REQ-027 The two-flop synchroniser SHALL be a separate sub-module named sync_2ff, reusable by the other clock domains.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, HOLD_CYCLES=10)
REQ-028 Release rst with locked tied high -> pll_rst high for 4 cycles; sys_reset falls and ready rises after 4 + 2-cycle sync + 10 hold cycles (±1 register cycle); lock_loss_cnt=0.
REQ-029 Keep locked low -> a pll_rst pulse of 4 cycles repeats every 4+100 cycles; sys_reset stays 1.
REQ-030 Glitch locked low for 3 cycles at hold cycle 6 -> return to WAIT, then the full 10-cycle hold restarts; ready rises only after 10 uninterrupted cycles.
REQ-031 In RUN, drop locked -> within 3 cycles sys_reset=1, ready=0, pll_rst=1, lock_loss_cnt=1; repeat 300 times -> lock_loss_cnt=255.
REQ-032 In RUN, pulse soft_reset for 1 cycle -> sys_reset=1 for 10 cycles with pll_rst=0; assert soft_reset in the same cycle locked_s falls -> PLLRST entered and lock_loss_cnt increments.
